mdu_unit: RTL

- Multiply/divide responder in the E stage of the 5-stage MIPS pipeline.
- Consumes the decoder's MDUop/Start pair together with forwarded rs/rt operands.
- Owns the HI/LO registers and runs multi-cycle mult/multu/div/divu.
- Drives Busy for the hazard unit (stall condition is Start|Busy for Md/Mf/Mt instructions) and drives HI/LO read data for mfhi/mflo.

---
 rtl/mdu_unit_pkg.sv | 34 +++
 rtl/mdu_divider.sv | 38 +++
 rtl/mdu_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MDUop encoding,
// FSM states and the HI/LO payload type.
package mdu_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] MDUOP_NULL  = 4'd0;
  localparam logic [OP_W-1:0] MDUOP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDUOP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDUOP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDUOP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDUOP_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MDUOP_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MDUOP_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MDUOP_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // True for the four multi-cycle arithmetic operations
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == MDUOP_MULT) || (op == MDUOP_MULTU) ||
           (op == MDUOP_DIV)  || (op == MDUOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit divider: truncating quotient, remainder carries the
// dividend's sign. Works on magnitudes so -2^31 / -1 is well defined.
module mdu_divider
  import mdu_unit_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            div_zero
);

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;

  always_comb begin
    a_neg    = is_signed & a[XLEN-1];
    b_neg    = is_signed & b[XLEN-1];
    div_zero = (b == '0);
    a_mag    = a_neg ? XLEN'(-a) : a;
    // Divisor forced to 1 on zero so the datapath never produces X
    if (div_zero) begin
      b_mag = XLEN'(1);
    end else begin
      b_mag = b_neg ? XLEN'(-b) : b;
    end
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quot  = (a_neg ^ b_neg) ? XLEN'(-q_mag) : q_mag;
    rem   = a_neg ? XLEN'(-r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div
// operations and exposes Busy for the hazard unit plus mfhi/mflo read data.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [OP_W-1:0] MDUop,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Req,
  output logic            Busy,
  output logic [XLEN-1:0] Out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             dz_q, dz_d;
  hilo_t            hilo_q, hilo_d;
  hilo_t            tmp_q, tmp_d;

  logic              accept_c;
  logic [2*XLEN-1:0] prod_s_c;
  logic [2*XLEN-1:0] prod_u_c;
  logic [XLEN-1:0]   quot_c;
  logic [XLEN-1:0]   rem_c;
  logic              div_zero_c;

  // Full 64-bit products via explicit sign/zero extension
  assign prod_s_c = {{XLEN{A[XLEN-1]}}, A} * {{XLEN{B[XLEN-1]}}, B};
  assign prod_u_c = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

  mdu_divider u_divider (
    .a         (A),
    .b         (B),
    .is_signed (MDUop == MDUOP_DIV),
    .quot      (quot_c),
    .rem       (rem_c),
    .div_zero  (div_zero_c)
  );

  assign accept_c = Start & ~busy_q & ~Req & is_arith(MDUop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      hilo_q  <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
      hilo_q  <= hilo_d;
      tmp_q   <= tmp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    hilo_d  = hilo_q;
    tmp_d   = tmp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          dz_d    = 1'b0;
          case (MDUop)
            MDUOP_MULT: begin
              tmp_d = prod_s_c;
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            MDUOP_MULTU: begin
              tmp_d = prod_u_c;
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            default: begin
              tmp_d.hi = rem_c;
              tmp_d.lo = quot_c;
              dz_d     = div_zero_c;
              cnt_d    = CNT_W'(DIV_CYCLES);
            end
          endcase
        end else if (!Req) begin
          if (MDUop == MDUOP_MTHI) hilo_d.hi = A;
          if (MDUop == MDUOP_MTLO) hilo_d.lo = A;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Commit on the last busy edge; divide-by-zero leaves HI/LO alone
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (!dz_q) hilo_d = tmp_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign Busy = busy_q;

  always_comb begin
    Out = '0;
    if (MDUop == MDUOP_MFHI) Out = hilo_q.hi;
    if (MDUop == MDUOP_MFLO) Out = hilo_q.lo;
  end

endmodule
